alu_arbiter: RTL

- Shares one combinational ALU datapath (4-bit selector; codes 0-8 = add, sub, and, or, nor, xor, shl, shr, sra; others return 0) between REQ requesters.
- Round-robin arbitration, operand/opcode latching, ALU drive, result capture, valid/ready response handshake.
- Sits between the pipeline's functional-unit clients and the single shared ALU instance.

---
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU among REQ requesters
// Optional opcode checking (rsp_err, illegal opcodes masked) under ALU_ARBITER_OPCHECK_EN.
module alu_arbiter #(
    parameter int N   = 8,
    parameter int REQ = 4,
    parameter int IDW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REQ-1:0]     req_valid,
    input  logic [REQ*N-1:0]   req_a,
    input  logic [REQ*N-1:0]   req_b,
    input  logic [REQ*4-1:0]   req_op,
    output logic [REQ-1:0]     req_ready,
    output logic [N-1:0]       alu_a,
    output logic [N-1:0]       alu_b,
    output logic [3:0]         alu_sel,
    input  logic [N-1:0]       alu_y,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [N-1:0]       rsp_data,
    input  logic               rsp_ready,
`ifdef ALU_ARBITER_OPCHECK_EN
    output logic               rsp_err,
`endif
    output logic               busy
);

    localparam logic [3:0] OP_MAX = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t         r_state;
    logic [IDW-1:0] r_rr;
    logic [IDW-1:0] r_rsp_id;
    logic [N-1:0]   r_alu_a;
    logic [N-1:0]   r_alu_b;
    logic [3:0]     r_alu_sel;
    logic [N-1:0]   r_rsp_data;
    logic           r_rsp_valid;
    logic           r_busy;
`ifdef ALU_ARBITER_OPCHECK_EN
    logic           r_illegal;
    logic           r_rsp_err;
`endif

    logic           w_found;
    logic [IDW-1:0] w_gidx;
    logic [N-1:0]   w_ga;
    logic [N-1:0]   w_gb;
    logic [3:0]     w_gop;
    logic           w_illegal;
    logic [IDW-1:0] w_rr_next;

    // Scan downward so the candidate closest to the rr pointer is the last writer.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(r_rr) + k;
            if (idx >= REQ) idx = idx - REQ;
            if (req_valid[idx]) begin
                w_found = 1'b1;
                w_gidx  = IDW'(idx);
            end
        end
    end

    assign w_ga      = req_a[w_gidx*N +: N];
    assign w_gb      = req_b[w_gidx*N +: N];
    assign w_gop     = req_op[w_gidx*4 +: 4];
    assign w_illegal = (w_gop > OP_MAX);
    assign w_rr_next = (r_rsp_id == IDW'(REQ - 1)) ? '0 : r_rsp_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_found) req_ready[w_gidx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_rsp_id    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef ALU_ARBITER_OPCHECK_EN
            r_illegal   <= 1'b0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_alu_a  <= w_ga;
                        r_alu_b  <= w_gb;
`ifdef ALU_ARBITER_OPCHECK_EN
                        r_alu_sel <= w_illegal ? 4'd0 : w_gop;
                        r_illegal <= w_illegal;
`else
                        r_alu_sel <= w_gop;
`endif
                        r_rsp_id <= w_gidx;
                        r_busy   <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef ALU_ARBITER_OPCHECK_EN
                    r_rsp_data <= r_illegal ? '0 : alu_y;
                    r_rsp_err  <= r_illegal;
`else
                    r_rsp_data <= alu_y;
`endif
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_rr        <= w_rr_next;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Without opcode checking, codes above 8 reach the ALU as-is; its 0 result is captured.
    logic w_unused_illegal;
    assign w_unused_illegal = w_illegal;

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;
`ifdef ALU_ARBITER_OPCHECK_EN
    assign rsp_err   = r_rsp_err;
`endif

endmodule
